// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store sequencer between the pipeline and the data memory port.
// Latency: request is issued the cycle after an aligned access is seen; DONE follows the dmem_ack cycle.
// Backpressure: combinational stall holds the pipeline from the access cycle through every REQ cycle.
// Optional build macro MEM_TIMEOUT_EN: abort a request that sees no dmem_ack within TIMEOUT REQ cycles.
module mem_access_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    input  logic        flush,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        err_flag,
    output logic [1:0]  err_code
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // The counter is 8 bits wide, so the abort threshold must fit in it.
    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range
        $error("mem_access_ctrl: TIMEOUT must lie in 2..255");
    end

    state_t r_state;
    state_t w_next;
    logic   w_access;
    logic   w_aligned;
    logic   w_timeout;
    logic   r_is_read;
    logic   r_flushed;

    // A flushed instruction is not an access; an access with a write is always a store.
    assign w_access  = (mem_read_in | mem_write_in) & ~flush;
    assign w_aligned = (addr_in[1:0] == 2'b00);

`ifdef MEM_TIMEOUT_EN
    logic [7:0] r_tmo_cnt;

    // Abort fires on the TIMEOUT-th consecutive REQ cycle without an ack.
    assign w_timeout = (r_state == S_REQ) && !dmem_ack && (r_tmo_cnt == 8'(TIMEOUT - 1));

    // Wait counter: cleared on REQ entry, counts REQ cycles that see no ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= 8'd0;
        end else if (r_state == S_IDLE && w_access && w_aligned) begin
            r_tmo_cnt <= 8'd0;
        end else if (r_state == S_REQ && !dmem_ack && !w_timeout) begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
        end
    end
`else
    // Without the timeout option REQ waits for dmem_ack indefinitely.
    assign w_timeout = 1'b0;
`endif

    // Next-state and stall decode; stall is forced low while reset is held.
    always_comb begin
        w_next = r_state;
        stall  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_access && w_aligned) begin
                    stall  = 1'b1;
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                stall = 1'b1;
                if (dmem_ack || w_timeout) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                // Pipeline advances at the end of DONE; inputs here belong to the old instruction.
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (rst) begin
            stall = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Memory request, load return and sticky error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_wdata <= 32'd0;
            load_data  <= 32'd0;
            load_valid <= 1'b0;
            err_flag   <= 1'b0;
            err_code   <= 2'b00;
            r_is_read  <= 1'b0;
            r_flushed  <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_access) begin
                        if (w_aligned) begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= mem_write_in;
                            dmem_addr  <= addr_in;
                            dmem_wdata <= wdata_in;
                            r_is_read  <= ~mem_write_in;
                            r_flushed  <= 1'b0;
                        end else begin
                            err_flag <= 1'b1;
                            err_code <= 2'b01;
                        end
                    end
                end
                S_REQ: begin
                    // A flush cannot cancel an issued request; it only hides the load result.
                    if (flush) begin
                        r_flushed <= 1'b1;
                    end
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        if (r_is_read) begin
                            load_data  <= dmem_rdata;
                            load_valid <= ~(r_flushed | flush);
                        end
                    end else if (w_timeout) begin
                        dmem_req  <= 1'b0;
                        load_data <= 32'd0;
                        err_flag  <= 1'b1;
                        err_code  <= 2'b10;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed checks of mem_access_ctrl with a load-result scoreboard.
// Expected load data is queued when the bench returns dmem_ack and popped on each load_valid.
// Every wait on the DUT is bounded so the run always reaches its summary line.
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst;
    logic        mem_read_in;
    logic        mem_write_in;
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    logic        flush;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        err_flag;
    logic [1:0]  err_code;

    int n_tests = 0;
    int n_fail  = 0;
    int lv_cnt  = 0;
    logic [31:0] exp_q[$];

    mem_access_ctrl #(.TIMEOUT(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read_in  (mem_read_in),
        .mem_write_in (mem_write_in),
        .addr_in      (addr_in),
        .wdata_in     (wdata_in),
        .flush        (flush),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata),
        .stall        (stall),
        .load_data    (load_data),
        .load_valid   (load_valid),
        .err_flag     (err_flag),
        .err_code     (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: every load_valid pulse must match the oldest queued read result.
    always @(negedge clk) begin
        if (load_valid === 1'b1) begin
            check("lv_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                check("load_data_sb", load_data, exp_q.pop_front());
            end
            lv_cnt++;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   32'(dmem_req),   32'd0);
        check({tag, "_we"},    32'(dmem_we),    32'd0);
        check({tag, "_addr"},  dmem_addr,       32'd0);
        check({tag, "_wdata"}, dmem_wdata,      32'd0);
        check({tag, "_ldata"}, load_data,       32'd0);
        check({tag, "_lv"},    32'(load_valid), 32'd0);
        check({tag, "_eflag"}, 32'(err_flag),   32'd0);
        check({tag, "_ecode"}, 32'(err_code),   32'd0);
    endtask

    // Drive one access from IDLE, answer with dmem_ack after ack_dly REQ cycles
    // (never, if ack_dly exceeds the REQ length), and return in the following IDLE cycle.
    task automatic run_access(input logic rd, input logic we, input logic [31:0] a,
                              input logic [31:0] wd, input int ack_dly,
                              input logic [31:0] rdat, input logic do_flush,
                              output int n_stall, output int n_req);
        bit done;
        n_stall = 0;
        n_req   = 0;
        done    = 1'b0;
        mem_read_in  = rd;
        mem_write_in = we;
        addr_in      = a;
        wdata_in     = wd;
        for (int g = 0; g < 64 && !done; g++) begin
            #1;
            if (stall === 1'b1) n_stall++;
            if (dmem_req === 1'b1) begin
                check("req_addr", dmem_addr, a);
                check("req_we", 32'(dmem_we), 32'(we));
                if (we) check("req_wdata", dmem_wdata, wd);
                flush = do_flush && (n_req == 0);
                if (n_req == ack_dly) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = rdat;
                    if (rd && !we && !do_flush) exp_q.push_back(rdat);
                end
                n_req++;
            end
            @(posedge clk);
            #1;
            dmem_ack = 1'b0;
            flush    = 1'b0;
            if (n_req > 0 && dmem_req === 1'b0) done = 1'b1;
        end
        check("access_bound", 32'(done), 32'd1);
        // DONE: inputs still held, they must not start a new access.
        check("done_req", 32'(dmem_req), 32'd0);
        check("done_stall", 32'(stall), 32'd0);
        step();
        check("idle_no_resample", 32'(dmem_req), 32'd0);
        mem_read_in  = 1'b0;
        mem_write_in = 1'b0;
    endtask

    initial begin
        int ns, nr, lv0;
        rst          = 1'b1;
        mem_read_in  = 1'b1;
        mem_write_in = 1'b0;
        addr_in      = 32'h0000_0010;
        wdata_in     = 32'd0;
        flush        = 1'b0;
        dmem_ack     = 1'b0;
        dmem_rdata   = 32'd0;

        // Reset with an access pending: stall stays low, outputs at reset values.
        step();
        check("rst_stall", 32'(stall), 32'd0);
        step();
        check_reset_outputs("rst");
        mem_read_in = 1'b0;
        rst = 1'b0;
        step();

        // Load 0x100, ack three cycles after request.
        lv0 = lv_cnt;
        run_access(1'b1, 1'b0, 32'h100, 32'd0, 3, 32'hDEAD_BEEF, 1'b0, ns, nr);
        check("ld_stall_cycles", 32'(ns), 32'd5);
        check("ld_req_cycles", 32'(nr), 32'd4);
        check("ld_lv_pulses", 32'(lv_cnt - lv0), 32'd1);
        check("ld_data", load_data, 32'hDEAD_BEEF);
        check("ld_no_err", 32'(err_flag), 32'd0);

        // Store 0x204, ack in first REQ cycle.
        lv0 = lv_cnt;
        run_access(1'b0, 1'b1, 32'h204, 32'h1234_5678, 0, 32'hFFFF_FFFF, 1'b0, ns, nr);
        check("st_stall_cycles", 32'(ns), 32'd2);
        check("st_req_cycles", 32'(nr), 32'd1);
        check("st_lv_pulses", 32'(lv_cnt - lv0), 32'd0);
        check("st_ldata_kept", load_data, 32'hDEAD_BEEF);

        // Misaligned load 0x103.
        mem_read_in = 1'b1;
        addr_in     = 32'h103;
        #1;
        check("mis_stall", 32'(stall), 32'd0);
        step();
        mem_read_in = 1'b0;
        check("mis_req", 32'(dmem_req), 32'd0);
        check("mis_eflag", 32'(err_flag), 32'd1);
        check("mis_ecode", 32'(err_code), 32'd1);
        step();
        check("mis_sticky", 32'(err_flag), 32'd1);

        // Identical back-to-back stores; the second also has read set (write wins).
        lv0 = lv_cnt;
        run_access(1'b0, 1'b1, 32'h300, 32'hAAAA_0001, 1, 32'd0, 1'b0, ns, nr);
        check("st2a_req_cycles", 32'(nr), 32'd2);
        run_access(1'b1, 1'b1, 32'h300, 32'hAAAA_0002, 0, 32'h7777_7777, 1'b0, ns, nr);
        check("st2b_req_cycles", 32'(nr), 32'd1);
        check("st2_lv_pulses", 32'(lv_cnt - lv0), 32'd0);
        check("st2_ldata_kept", load_data, 32'hDEAD_BEEF);

        // Stray ack in IDLE is ignored.
        lv0 = lv_cnt;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h9999_9999;
        step();
        dmem_ack = 1'b0;
        check("stray_req", 32'(dmem_req), 32'd0);
        check("stray_ldata", load_data, 32'hDEAD_BEEF);
        step();
        check("stray_lv", 32'(lv_cnt - lv0), 32'd0);

        // Flushed access in IDLE is not an access.
        mem_read_in = 1'b1;
        addr_in     = 32'h40;
        flush       = 1'b1;
        #1;
        check("fl_idle_stall", 32'(stall), 32'd0);
        step();
        mem_read_in = 1'b0;
        flush       = 1'b0;
        check("fl_idle_req", 32'(dmem_req), 32'd0);
        check("fl_idle_ecode", 32'(err_code), 32'd1);

        // Flush during REQ: request completes, load_valid suppressed.
        lv0 = lv_cnt;
        run_access(1'b1, 1'b0, 32'h80, 32'd0, 2, 32'h0000_0055, 1'b1, ns, nr);
        check("fl_req_cycles", 32'(nr), 32'd3);
        check("fl_stall_cycles", 32'(ns), 32'd4);
        check("fl_lv_pulses", 32'(lv_cnt - lv0), 32'd0);

`ifdef MEM_TIMEOUT_EN
        // No ack: abort after 16 REQ cycles with timeout error.
        lv0 = lv_cnt;
        run_access(1'b1, 1'b0, 32'h600, 32'd0, 1000, 32'd0, 1'b0, ns, nr);
        check("tmo_req_cycles", 32'(nr), 32'd16);
        check("tmo_stall_cycles", 32'(ns), 32'd17);
        check("tmo_eflag", 32'(err_flag), 32'd1);
        check("tmo_ecode", 32'(err_code), 32'd2);
        check("tmo_ldata", load_data, 32'd0);
        check("tmo_lv_pulses", 32'(lv_cnt - lv0), 32'd0);
`endif

        // Reset in REQ, then a late ack.
        mem_read_in = 1'b1;
        addr_in     = 32'h500;
        step();
        check("rq_req_up", 32'(dmem_req), 32'd1);
        rst         = 1'b1;
        mem_read_in = 1'b0;
        #1;
        check("rq_rst_stall", 32'(stall), 32'd0);
        step();
        rst = 1'b0;
        check_reset_outputs("rq");
        lv0 = lv_cnt;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h0000_0BAD;
        step();
        dmem_ack = 1'b0;
        check("late_ack_req", 32'(dmem_req), 32'd0);
        check("late_ack_ldata", load_data, 32'd0);
        step();
        check("late_ack_lv", 32'(lv_cnt - lv0), 32'd0);

        // Normal load after reset recovery.
        lv0 = lv_cnt;
        run_access(1'b1, 1'b0, 32'h8, 32'd0, 1, 32'hA5A5_5A5A, 1'b0, ns, nr);
        check("post_stall_cycles", 32'(ns), 32'd3);
        check("post_lv_pulses", 32'(lv_cnt - lv0), 32'd1);
        check("post_ldata", load_data, 32'hA5A5_5A5A);

        step();
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT, 16, max cycles REQ waits for dmem_ack before abort (legal 2..255).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 mem_read_in / mem_write_in  input  1 each  load/store request from EX/MEM stage.
REQ-005 addr_in  input  32  byte address (EX/MEM ALU result).
REQ-006 wdata_in  input  32  store data (EX/MEM rs2 data).
REQ-007 flush  input  1  kill current MEM-stage instruction.
REQ-008 dmem_req  output  1  registered memory request, held until ack or abort.
REQ-009 dmem_we  output  1  registered write enable, valid with dmem_req.
REQ-010 dmem_addr / dmem_wdata  output  32 each  registered address/data, stable while dmem_req=1.
REQ-011 dmem_ack  input  1  one-cycle completion from memory; dmem_rdata  input  32  valid with ack.
REQ-012 stall  output  1  combinational; holds PC, IF/ID, ID/EX, EX/MEM while 1.
REQ-013 load_data  output  32  registered read data; load_valid  output  1  one-cycle pulse.
REQ-014 err_flag  output  1  sticky error; err_code  output  2  01 misaligned, 10 timeout.

Function
REQ-015 FSM states IDLE, REQ, DONE; reset state IDLE.
REQ-016 Access = (mem_read_in | mem_write_in) & ~flush; mem_write_in has priority if both set (dmem_we=1).
REQ-017 IDLE, access, addr_in[1:0]==0: stall=1 this cycle; latch addr/data/we, dmem_req=1 next cycle, go REQ.
REQ-018 IDLE, access, addr_in[1:0]!=0: no request, stall=0, err_flag=1, err_code=01 next cycle, stay IDLE.
REQ-019 REQ: stall=1; dmem_addr, dmem_wdata, dmem_we constant.
REQ-020 REQ with dmem_ack: dmem_req=0 next cycle; for reads load_data<=dmem_rdata, load_valid=1 in DONE; go DONE.
REQ-021 Ack in first REQ cycle legal; minimum access latency 2 cycles (IDLE, REQ) plus DONE.
REQ-022 DONE: stall=0 so pipeline advances at end of DONE; new access not sampled in DONE; go IDLE.
REQ-023 dmem_ack outside REQ ignored, no state change.
REQ-024 flush during REQ does not drop dmem_req; transaction completes, load_valid suppressed in DONE.
REQ-025 Store: load_valid stays 0; load_data unchanged.
REQ-026 err_flag/err_code cleared only by rst; later error overwrites err_code.
REQ-027 Stores with identical back-to-back addresses issue separately; no merging.

Reset
REQ-028 rst: state IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, load_data=0, load_valid=0, err_flag=0, err_code=00, timeout counter=0.
REQ-029 rst in REQ abandons transaction; dmem_req=0 after edge; later ack ignored.
REQ-030 stall=0 while rst=1.

Configuration
REQ-031 Macro MEM_TIMEOUT_EN defined: 8-bit counter clears on REQ entry, increments each REQ cycle without ack; on TIMEOUT cycles without ack, dmem_req=0, load_data=0, load_valid=0, err_flag=1, err_code=10, go DONE.
REQ-032 MEM_TIMEOUT_EN undefined: no counter, REQ waits indefinitely for dmem_ack, err_code 10 never produced.

Verification
REQ-033 Load addr 0x100, ack 3 cycles after req, rdata 0xDEADBEEF -> stall 5 cycles, load_data=0xDEADBEEF, load_valid one pulse.
REQ-034 Store addr 0x204 wdata 0x12345678, ack first REQ cycle -> dmem_we=1, req 1 cycle, stall 2 cycles, no load_valid.
REQ-035 Load addr 0x103 -> no dmem_req, stall=0, err_flag=1, err_code=01.
REQ-036 MEM_TIMEOUT_EN, TIMEOUT=16, no ack -> req drops after 16 REQ cycles, err_code=10, stall drops in DONE.
REQ-037 flush asserted in REQ, ack rdata 0x55 -> transaction completes, load_valid=0.
REQ-038 rst in REQ then late ack -> IDLE, dmem_req=0, ack ignored, all outputs reset values.
